// File: rtl/ex_operand_stage.sv
// ============================================================================
// Module   : ex_operand_stage
// Purpose  : ID/EX register with MEM/WB forwarding and load-use stall detection
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_operand_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [XLEN-1:0]       id_pc,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [XLEN-1:0]       id_rs1_data,
    input  logic [XLEN-1:0]       id_rs2_data,
    input  logic [XLEN-1:0]       id_imm,
    input  logic [3:0]            id_alu_control,
    input  logic [1:0]            id_src_a_sel,
    input  logic                  id_src_b_sel,
    input  logic                  id_reg_write,
    input  logic                  id_mem_write,
    input  logic                  fwd_mem_valid,
    input  logic                  fwd_mem_is_load,
    input  logic [REG_ADDR_W-1:0] fwd_mem_rd,
    input  logic [XLEN-1:0]       fwd_mem_data,
    input  logic                  fwd_wb_valid,
    input  logic [REG_ADDR_W-1:0] fwd_wb_rd,
    input  logic [XLEN-1:0]       fwd_wb_data,
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output logic [XLEN-1:0]       ex_operand_a,
    output logic [XLEN-1:0]       ex_operand_b,
    output logic [3:0]            ex_alu_control,
    output logic [XLEN-1:0]       ex_pc,
    output logic [XLEN-1:0]       ex_imm,
    output logic [XLEN-1:0]       ex_store_data,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_reg_write,
    output logic                  ex_mem_write
);

    localparam logic [REG_ADDR_W-1:0] c_ZERO_REG = '0;
    localparam logic [1:0]            c_SRC_A_RS1 = 2'd0;
    localparam logic [1:0]            c_SRC_A_PC  = 2'd1;

    logic                  r_valid;
    logic [XLEN-1:0]       r_pc, r_imm, r_rs1_val, r_rs2_val;
    logic [REG_ADDR_W-1:0] r_rs1, r_rs2, r_rd;
    logic [3:0]            r_alu_control;
    logic [1:0]            r_src_a_sel;
    logic                  r_src_b_sel, r_reg_write, r_mem_write;

    logic [XLEN-1:0]       w_rs1_val, w_rs2_val;
    logic                  w_uses_rs1, w_uses_rs2, w_load_hazard, w_capture;
    logic                  w_wb_hit_rs1, w_wb_hit_rs2;

    // MEM (non-load) beats WB beats register file; x0 always reads zero.
    function automatic logic [XLEN-1:0] resolve(input logic [REG_ADDR_W-1:0] rs,
                                                input logic [XLEN-1:0] rf_data);
        if (rs == c_ZERO_REG)
            return '0;
        else if (fwd_mem_valid && !fwd_mem_is_load && fwd_mem_rd == rs)
            return fwd_mem_data;
        else if (fwd_wb_valid && fwd_wb_rd == rs)
            return fwd_wb_data;
        else
            return rf_data;
    endfunction

    always_comb begin
        w_rs1_val     = resolve(id_rs1, id_rs1_data);
        w_rs2_val     = resolve(id_rs2, id_rs2_data);
        w_uses_rs1    = (id_src_a_sel == c_SRC_A_RS1);
        w_uses_rs2    = !id_src_b_sel || id_mem_write;
        w_load_hazard = fwd_mem_valid && fwd_mem_is_load && (fwd_mem_rd != c_ZERO_REG) &&
                        ((w_uses_rs1 && fwd_mem_rd == id_rs1) ||
                         (w_uses_rs2 && fwd_mem_rd == id_rs2));
        id_ready      = !w_load_hazard && (!r_valid || ex_ready);
        w_capture     = id_valid && id_ready && !flush;
        w_wb_hit_rs1  = fwd_wb_valid && (fwd_wb_rd != c_ZERO_REG) && (fwd_wb_rd == r_rs1);
        w_wb_hit_rs2  = fwd_wb_valid && (fwd_wb_rd != c_ZERO_REG) && (fwd_wb_rd == r_rs2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid       <= 1'b0;
            r_pc          <= '0;
            r_imm         <= '0;
            r_rs1_val     <= '0;
            r_rs2_val     <= '0;
            r_rs1         <= '0;
            r_rs2         <= '0;
            r_rd          <= '0;
            r_alu_control <= '0;
            r_src_a_sel   <= '0;
            r_src_b_sel   <= 1'b0;
            r_reg_write   <= 1'b0;
            r_mem_write   <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid       <= 1'b1;
            r_pc          <= id_pc;
            r_imm         <= id_imm;
            r_rs1_val     <= w_rs1_val;
            r_rs2_val     <= w_rs2_val;
            r_rs1         <= id_rs1;
            r_rs2         <= id_rs2;
            r_rd          <= id_rd;
            r_alu_control <= id_alu_control;
            r_src_a_sel   <= id_src_a_sel;
            r_src_b_sel   <= id_src_b_sel;
            r_reg_write   <= id_reg_write;
            r_mem_write   <= id_mem_write;
        end else if (r_valid && ex_ready) begin
            r_valid <= 1'b0;
        end else if (r_valid) begin
            // A producer retiring while we stall would otherwise be lost.
            if (w_wb_hit_rs1) r_rs1_val <= fwd_wb_data;
            if (w_wb_hit_rs2) r_rs2_val <= fwd_wb_data;
        end
    end

    always_comb begin
        ex_operand_a = '0;
        if (r_src_a_sel == c_SRC_A_RS1)
            ex_operand_a = r_rs1_val;
        else if (r_src_a_sel == c_SRC_A_PC)
            ex_operand_a = r_pc;
    end

    assign ex_valid       = r_valid;
    assign ex_operand_b   = r_src_b_sel ? r_imm : r_rs2_val;
    assign ex_alu_control = r_alu_control;
    assign ex_pc          = r_pc;
    assign ex_imm         = r_imm;
    assign ex_store_data  = r_rs2_val;
    assign ex_rd          = r_rd;
    assign ex_reg_write   = r_reg_write;
    assign ex_mem_write   = r_mem_write;

endmodule

`default_nettype wire
